// File: rtl/register_file_sb.sv
`default_nettype none
// ============================================================================
//  Module   : register_file_sb
//  Desc     : Scoreboarded multi-port register file. Combinational reads with
//             same-cycle write bypass, hardwired zero register, and a
//             per-register pending-write counter for decode hazard checks.
//  Revision : 1.0 - initial release
// ============================================================================
module register_file_sb #(
  parameter  int DATA_W = 32,
  parameter  int DEPTH  = 32,
  parameter  int NRD    = 2,
  parameter  int NWR    = 2,
  parameter  int CNT_W  = 2,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic                  CLK,
  input  logic                  nRst,
  input  logic [NRD*AW-1:0]     rsel,
  output logic [NRD*DATA_W-1:0] rdat,
  output logic [NRD-1:0]        rbusy,
  input  logic [NWR-1:0]        wen,
  input  logic [NWR*AW-1:0]     wsel,
  input  logic [NWR*DATA_W-1:0] wdat,
  input  logic [NWR-1:0]        wclr,
  input  logic                  rsv_en,
  input  logic [AW-1:0]         rsv_sel,
  output logic                  rsv_rdy,
  input  logic                  flush
);

  // Width able to hold the number of write ports retiring one register.
  localparam int DW = $clog2(NWR + 1);
  // Arithmetic width for cnt + inc - dec without wrap.
  localparam int SW = CNT_W + DW + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [DATA_W-1:0] r_regs    [DEPTH];
  logic [CNT_W-1:0]  r_cnt     [DEPTH];
  logic [DW-1:0]     w_dec     [DEPTH];
  logic [SW-1:0]     w_sum     [DEPTH];
  logic [CNT_W-1:0]  w_cnt_nxt [DEPTH];
  logic              w_inc     [DEPTH];

  // Per-register retirement count this cycle (register 0 never retires).
  always_comb begin
    for (int r = 0; r < DEPTH; r++) begin
      w_dec[r] = '0;
      for (int p = 0; p < NWR; p++) begin
        if (r != 0 && wen[p] && wclr[p] && wsel[p*AW +: AW] == AW'(r)) begin
          w_dec[r] = w_dec[r] + DW'(1);
        end
      end
    end
  end

  // Reservation is refused only for a saturated counter with no retirement.
  always_comb begin
    rsv_rdy = (rsv_sel == '0) || (r_cnt[rsv_sel] != CNT_MAX) || (w_dec[rsv_sel] != '0);
  end

  // Next counter value: accepted reservation minus retirements, floored at 0.
  always_comb begin
    for (int r = 0; r < DEPTH; r++) begin
      w_inc[r]     = rsv_en && rsv_rdy && !flush && (r != 0) && (rsv_sel == AW'(r));
      w_sum[r]     = SW'(r_cnt[r]) + SW'(w_inc[r]);
      w_cnt_nxt[r] = '0;
      if (w_sum[r] > SW'(w_dec[r])) begin
        w_cnt_nxt[r] = CNT_W'(w_sum[r] - SW'(w_dec[r]));
      end
    end
  end

  // Read ports: array value overridden by in-cycle write data, highest port last.
  always_comb begin
    rdat  = '0;
    rbusy = '0;
    for (int i = 0; i < NRD; i++) begin
      rdat[i*DATA_W +: DATA_W] = r_regs[rsel[i*AW +: AW]];
      for (int p = 0; p < NWR; p++) begin
        if (wen[p] && wsel[p*AW +: AW] == rsel[i*AW +: AW]) begin
          rdat[i*DATA_W +: DATA_W] = wdat[p*DATA_W +: DATA_W];
        end
      end
      rbusy[i] = SW'(r_cnt[rsel[i*AW +: AW]]) > SW'(w_dec[rsel[i*AW +: AW]]);
      if (rsel[i*AW +: AW] == '0) begin
        rdat[i*DATA_W +: DATA_W] = '0;
        rbusy[i]                 = 1'b0;
      end
    end
  end

  // State update: register writes (higher port wins) and pending counters.
  always_ff @(posedge CLK or negedge nRst) begin
    if (!nRst) begin
      for (int r = 0; r < DEPTH; r++) begin
        r_regs[r] <= '0;
        r_cnt[r]  <= '0;
      end
    end else begin
      for (int p = 0; p < NWR; p++) begin
        if (wen[p] && wsel[p*AW +: AW] != '0) begin
          r_regs[wsel[p*AW +: AW]] <= wdat[p*DATA_W +: DATA_W];
        end
      end
      for (int r = 0; r < DEPTH; r++) begin
        r_cnt[r] <= flush ? '0 : w_cnt_nxt[r];
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/register_file_sb.md
# register_file_sb

Parametrised, scoreboarded register file for the pipelined datapath. It provides multi-port reads, multi-port writes and a hardwired zero register. Same-cycle write-to-read bypass replaces negedge writes, so all state updates on the rising edge. A per-register pending-write counter gives hazard/stall information to decode.

## Interface
- DATA_W, 32, register width in bits
- DEPTH, 32, number of registers (power of two, ≥2); AW = $clog2(DEPTH)
- NRD, 2, number of read ports
- NWR, 2, number of write ports; higher index has priority on address collision
- CNT_W, 2, width of each pending-write counter (max outstanding writes per register = 2^CNT_W − 1)
- CLK  in  1  clock; all state updates on rising edge
- nRst  in  1  asynchronous active-low reset
- rsel  in  NRD*AW  read select, port i at [i*AW +: AW]
- rdat  out  NRD*DATA_W  read data, port i at [i*DATA_W +: DATA_W]
- rbusy  out  NRD  port i source has ≥1 pending write not yet landed or bypassed this cycle
- wen  in  NWR  write enable per port
- wsel  in  NWR*AW  write select per port
- wdat  in  NWR*DATA_W  write data per port
- wclr  in  NWR  retire one pending reservation for wsel of that port (qualified by wen)
- rsv_en  in  1  decode requests reservation of rsv_sel
- rsv_sel  in  AW  destination register being issued
- rsv_rdy  out  1  reservation accepted this cycle (rsv_en && rsv_rdy = handshake)
- flush  in  1  synchronous clear of all pending counters (pipeline squash)

## Operation
- Register 0: reads always return 0, rbusy always 0, writes/reservations to it ignored (rsv_rdy=1, counter untouched).
- Write: on rising edge, for each port with wen=1 and wsel≠0, reg[wsel] ← wdat. If two ports hit the same address, the higher-index port's data is stored.
- Read (combinational): rdat[i] = matching in-cycle write data if any port has wen=1 and wsel==rsel[i]≠0 (highest index wins); otherwise reg[rsel[i]]; 0 if rsel[i]==0.
- Pending counter cnt[r] (CNT_W bits, one per register 1..DEPTH−1):
  - inc = rsv_en && rsv_rdy && rsv_sel==r
  - dec = count of write ports with wen && wclr && wsel==r, r≠0. Two ports retiring the same register decrement by 2.
  - next = cnt + inc − dec; both inc and dec nonzero in the same cycle net out.
  - Decrement below 0 clamps at 0 (protocol error, no flag).
- rsv_rdy = 0 only when cnt[rsv_sel] == 2^CNT_W − 1 and no retirement of rsv_sel occurs this cycle. A saturated counter with a same-cycle wclr accepts the new reservation.
- rbusy[i] = (cnt[rsel[i]] − dec for rsel[i] this cycle) > 0. A retirement landing this cycle clears busy combinationally along with the bypass.
- flush: all counters → 0 on next edge and reservations that cycle are discarded. Writes in the same cycle still update register contents.

## Timing
- Reset (nRst low, async): all registers 0, all counters 0. Outputs during reset: rdat=0, rbusy=0, rsv_rdy=1.
- Deassertion is sampled by the next rising edge; no operation is lost mid-cycle beyond the async clear.
- Read latency 0 (combinational including bypass). Write/counter latency 1 edge.
- Reservation handshake completes in the cycle rsv_en && rsv_rdy; rsv_rdy never depends on rsv_en.
- Reset mid-operation: all pending reservations are lost and counters read 0 immediately.
- No combinational path from rdat/rbusy to any input other than rsel, wen, wsel, wdat, wclr, rsv_sel.

## Test plan
- Reset/zero: after reset with DATA_W=32, read all ports across every address → 0. Write 0xDEADBEEF to r0 → rdat for r0 stays 0.
- Bypass and priority: wen=2'b11, wsel={5,5}, wdat={0xAAAA0001 (port1), 0x55550000 (port0)}, rsel0=5 → same-cycle rdat0=0xAAAA0001. Next cycle with no write → 0xAAAA0001.
- Scoreboard: reserve r7 → next cycle rbusy for r7=1. Write r7 with wclr → rbusy=0 in that cycle and rdat shows the new data.
- Saturation (CNT_W=2): reserve r3 three times → rsv_rdy=0 for r3 while rsv_rdy=1 for r4. Fourth reservation plus a same-cycle wclr on r3 → accepted, cnt stays 3.
- Simultaneous inc/dec and double retire: cnt[9]=2. Reserve r9 with wclr on r9 → stays 2. Two ports wclr r9 → 0, rbusy=0.
- Flush and async reset: cnt nonzero on several registers. Flush with rsv_en → all rbusy=0 next cycle and the write still lands. Assert nRst mid-cycle → rdat=0 and rbusy=0 without a clock edge.
